// File: rtl/acq_scheduler.sv
// Measurement sequencer: periodically starts the mic subsystem, waits for done with a timeout,
// averages 2^AVG_LOG2 settled angles and hands the result to the UART.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | stopped; accumulator and sample count held at zero
// START     | one-cycle start pulse; period and timeout timers loaded
// WAIT_DONE | waiting for subsys_done, timeout timer running
// SETTLE    | waiting ANGLE_LAT cycles after done, then sampling angel_in
// SEND      | average ready but UART busy; holding until uart_ready
// GAP       | waiting for the period timer to expire before next START
module acq_scheduler #(
    parameter int PERIOD_CYC  = 6_000_000,
    parameter int TIMEOUT_CYC = 3_000_000,
    parameter int ANGLE_LAT   = 2,
    parameter int AVG_LOG2    = 2
) (
    input  logic        clk_60MHz,
    input  logic        rst,
    input  logic        run_en,
    output logic        subsys_start,
    input  logic        subsys_done,
    input  logic [15:0] angel_in,
    output logic [15:0] uart_data,
    output logic        uart_ena,
    input  logic        uart_ready,
    output logic        busy,
    output logic        err_timeout,
    output logic [7:0]  timeout_cnt
);
    localparam int PW = $clog2(PERIOD_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int AW = 16 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int NS = 1 << AVG_LOG2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_DONE, S_SETTLE, S_SEND, S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        per_q, per_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [3:0]           lat_q, lat_d;
    logic signed [AW-1:0] acc_q, acc_d, acc_smp;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_smp;
    logic                 subsys_start_q, subsys_start_d;
    logic                 uart_ena_q, uart_ena_d;
    logic                 busy_q, busy_d;
    logic                 err_timeout_q, err_timeout_d;
    logic [15:0]          uart_data_q, uart_data_d;
    logic [7:0]           timeout_cnt_q, timeout_cnt_d;

    always_comb begin
        state_d        = state_q;
        per_d          = per_q;
        tmo_d          = tmo_q;
        lat_d          = lat_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        uart_data_d    = uart_data_q;
        timeout_cnt_d  = timeout_cnt_q;
        subsys_start_d = 1'b0;
        uart_ena_d     = 1'b0;
        err_timeout_d  = 1'b0;
        acc_smp        = acc_q + AW'($signed(angel_in));
        cnt_smp        = cnt_q + CW'(1);

        if (state_q != S_IDLE && per_q != '0) per_d = per_q - PW'(1);
        if ((state_q == S_START || state_q == S_WAIT_DONE) && tmo_q != '0) tmo_d = tmo_q - TW'(1);
        if (state_q == S_SETTLE && lat_q != '0) lat_d = lat_q - 4'd1;

        case (state_q)
            S_IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (run_en) state_d = S_START;
            end
            S_START: state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (subsys_done) begin
                    state_d = S_SETTLE;
                    lat_d   = 4'(ANGLE_LAT - 1);
                end else if (tmo_q == '0) begin
                    err_timeout_d = 1'b1;
                    if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
                    state_d = S_GAP;
                end
            end
            S_SETTLE: begin
                if (lat_q == '0) begin
                    acc_d = acc_smp;
                    cnt_d = cnt_smp;
                    if (cnt_smp == CW'(NS)) begin
                        uart_data_d = 16'(acc_smp >>> AVG_LOG2);
                        // UART already idle: issue the request straight away so it lands
                        // ANGLE_LAT+1 cycles after done; otherwise park in SEND.
                        if (uart_ready) begin
                            uart_ena_d = 1'b1;
                            acc_d      = '0;
                            cnt_d      = '0;
                            state_d    = S_GAP;
                        end else begin
                            state_d = S_SEND;
                        end
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_SEND: begin
                if (uart_ready) begin
                    uart_ena_d = 1'b1;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                if (per_q == '0) state_d = run_en ? S_START : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_START) begin
            subsys_start_d = 1'b1;
            per_d          = PW'(PERIOD_CYC - 1);
            tmo_d          = TW'(TIMEOUT_CYC - 1);
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_60MHz) begin
        if (rst) begin
            state_q        <= S_IDLE;
            per_q          <= '0;
            tmo_q          <= '0;
            lat_q          <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            uart_data_q    <= '0;
            timeout_cnt_q  <= '0;
            subsys_start_q <= 1'b0;
            uart_ena_q     <= 1'b0;
            busy_q         <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            per_q          <= per_d;
            tmo_q          <= tmo_d;
            lat_q          <= lat_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            uart_data_q    <= uart_data_d;
            timeout_cnt_q  <= timeout_cnt_d;
            subsys_start_q <= subsys_start_d;
            uart_ena_q     <= uart_ena_d;
            busy_q         <= busy_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign subsys_start = subsys_start_q;
    assign uart_ena     = uart_ena_q;
    assign busy         = busy_q;
    assign err_timeout  = err_timeout_q;
    assign uart_data    = uart_data_q;
    assign timeout_cnt  = timeout_cnt_q;
endmodule

// File: tb/tb_acq_scheduler.sv
// Bench for acq_scheduler: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_acq_scheduler;
    localparam int P = 100;
    localparam int T = 40;
    localparam int L = 2;
    localparam int N = 4;

    logic        clk_60MHz = 1'b0;
    logic        rst = 1'b1;
    logic        run_en = 1'b0;
    logic        subsys_done = 1'b0;
    logic        uart_ready = 1'b1;
    logic [15:0] angel_in = 16'd0;
    logic        subsys_start, uart_ena, busy, err_timeout;
    logic [15:0] uart_data;
    logic [7:0]  timeout_cnt;

    acq_scheduler #(.PERIOD_CYC(P), .TIMEOUT_CYC(T), .ANGLE_LAT(L), .AVG_LOG2(2)) dut (
        .clk_60MHz(clk_60MHz), .rst(rst), .run_en(run_en), .subsys_start(subsys_start),
        .subsys_done(subsys_done), .angel_in(angel_in), .uart_data(uart_data),
        .uart_ena(uart_ena), .uart_ready(uart_ready), .busy(busy),
        .err_timeout(err_timeout), .timeout_cnt(timeout_cnt)
    );

    always #5 clk_60MHz = ~clk_60MHz;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int floor_div(int a, int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // ---------------- reference model (absolute cycle timestamps) ----------------
    int   ph = 0;      // 0 stopped, 1 measuring, 2 settling, 3 report pending, 4 waiting period
    int   t_s = 0;
    int   t_smp = 0;
    int   sum = 0;
    int   cnt = 0;
    bit   mvalid = 1'b0;
    logic e_start = 1'b0, e_ena = 1'b0, e_err = 1'b0, e_busy = 1'b0;
    logic [15:0] e_data = 16'd0;
    logic [7:0]  e_tcnt = 8'd0;

    task automatic begin_start(int c);
        e_start = 1'b1;
        t_s = c;
        ph = 1;
    endtask

    task automatic try_send();
        if (uart_ready) begin
            e_ena = 1'b1;
            sum = 0;
            cnt = 0;
            ph = 4;
        end
    endtask

    // Consumes the inputs of cycle n and yields the outputs expected in cycle n+1.
    task automatic model_step(int n);
        e_start = 1'b0;
        e_ena = 1'b0;
        e_err = 1'b0;
        if (rst) begin
            ph = 0; sum = 0; cnt = 0;
            e_data = 16'd0; e_tcnt = 8'd0; e_busy = 1'b0;
            mvalid = 1'b1;
            return;
        end
        case (ph)
            0: begin
                sum = 0; cnt = 0;
                if (run_en) begin_start(n + 1);
            end
            1: begin
                if (n > t_s && subsys_done) begin
                    ph = 2;
                    t_smp = n + L;
                end else if (n == t_s + T - 1) begin
                    e_err = 1'b1;
                    if (e_tcnt != 8'd255) e_tcnt = e_tcnt + 8'd1;
                    ph = 4;
                end
            end
            2: begin
                if (n == t_smp) begin
                    sum = sum + int'($signed(angel_in));
                    cnt++;
                    if (cnt == N) begin
                        e_data = 16'(floor_div(sum, N));
                        ph = 3;
                        try_send();
                    end else begin
                        ph = 4;
                    end
                end
            end
            3: try_send();
            default: begin
                if (n >= t_s + P - 1) begin
                    if (run_en) begin_start(n + 1);
                    else ph = 0;
                end
            end
        endcase
        e_busy = (ph != 0);
    endtask

    always @(posedge clk_60MHz) begin
        model_step(cyc);
        cyc = cyc + 1;
    end

    // ---------------- compare + event log ----------------
    int          start_log[$];
    int          ena_log[$];
    int          err_log[$];
    logic [15:0] data_log[$];

    always @(negedge clk_60MHz) begin
        if (mvalid) begin
            check("subsys_start", subsys_start, e_start);
            check("uart_ena", uart_ena, e_ena);
            check("err_timeout", err_timeout, e_err);
            check("busy", busy, e_busy);
            check("uart_data", uart_data, e_data);
            check("timeout_cnt", timeout_cnt, e_tcnt);
        end
        if (subsys_start === 1'b1) start_log.push_back(cyc);
        if (uart_ena === 1'b1) begin
            ena_log.push_back(cyc);
            data_log.push_back(uart_data);
        end
        if (err_timeout === 1'b1) err_log.push_back(cyc);
    end

    // ---------------- mic subsystem responder ----------------
    typedef struct {int delay; int angle; int stray;} plan_t;
    plan_t plans[$];
    plan_t cur;
    int done_at = -1, ang_at = -1, stray_at = -1, ang_val = 0;

    always @(negedge clk_60MHz) begin
        if (subsys_start === 1'b1) begin
            if (plans.size() > 0) cur = plans.pop_front();
            else cur = '{int'($urandom_range(1, 50)), int'($urandom_range(0, 65535)), -1};
            done_at  = (cur.delay < 0) ? -1 : cyc + cur.delay;
            ang_at   = (cur.delay < 0) ? -1 : cyc + cur.delay + L;
            stray_at = (cur.stray < 0) ? -1 : cyc + cur.stray;
            ang_val  = cur.angle;
        end
        subsys_done = (cyc == done_at) || (cyc == stray_at);
        angel_in    = (cyc == ang_at) ? 16'(ang_val) : 16'($urandom);
    end

    // ---------------- directed sequence ----------------
    task automatic tick();
        @(negedge clk_60MHz);
        #1;
    endtask

    task automatic wait_starts(int k, int lim, string name);
        int i = 0;
        while (start_log.size() < k && i < lim) begin tick(); i++; end
        check(name, start_log.size() >= k, 1);
    endtask

    task automatic wait_enas(int k, int lim, string name);
        int i = 0;
        while (ena_log.size() < k && i < lim) begin tick(); i++; end
        check(name, ena_log.size() >= k, 1);
    endtask

    initial begin
        int n0, r, nst, ne, s4;
        rst = 1'b1;
        repeat (5) tick();
        check("rst_busy", busy, 0);
        check("rst_start", subsys_start, 0);
        check("rst_data", uart_data, 0);
        check("rst_tcnt", timeout_cnt, 0);

        // test 2/3/4 measurement plans
        plans.push_back('{10, 10, -1});
        plans.push_back('{10, 20, -1});
        plans.push_back('{10, 30, -1});
        plans.push_back('{10, 41, -1});
        plans.push_back('{10, -1, 60});
        plans.push_back('{10, -2, 0});
        plans.push_back('{10, -2, -1});
        plans.push_back('{10, -2, -1});
        plans.push_back('{-1, 0, -1});
        plans.push_back('{39, 100, -1});
        plans.push_back('{1, 200, -1});
        plans.push_back('{10, 300, -1});
        plans.push_back('{10, 400, -1});

        rst = 1'b0;
        tick();
        run_en = 1'b1;
        n0 = cyc;
        wait_enas(1, 600, "wait_report1");
        if (start_log.size() >= 4 && ena_log.size() >= 1) begin
            check("first_start_latency", start_log[0], n0 + 1);
            check("spacing_1", start_log[1] - start_log[0], 100);
            check("spacing_2", start_log[2] - start_log[1], 100);
            check("spacing_3", start_log[3] - start_log[2], 100);
            check("report1_latency", ena_log[0], start_log[3] + 10 + 3);
            check("report1_data", data_log[0], 25);
            check("report1_single", ena_log.size(), 1);
        end

        wait_enas(2, 500, "wait_report2");
        if (start_log.size() >= 8 && ena_log.size() >= 2) begin
            check("report2_data", data_log[1], 16'hFFFE);
            check("report2_latency", ena_log[1], start_log[7] + 13);
            check("spacing_4_7", start_log[7] - start_log[4], 300);
        end

        wait_enas(3, 700, "wait_report3");
        if (start_log.size() >= 13 && ena_log.size() >= 3 && err_log.size() >= 1) begin
            check("timeout_count_evt", err_log.size(), 1);
            check("timeout_at", err_log[0], start_log[8] + 40);
            check("timeout_cnt", timeout_cnt, 1);
            check("spacing_after_timeout", start_log[9] - start_log[8], 100);
            check("report3_data", data_log[2], 250);
            check("report3_latency", ena_log[2], start_log[12] + 13);
        end

        // test 5: UART stall at SEND
        plans.push_back('{10, 5, -1});
        plans.push_back('{10, 6, -1});
        plans.push_back('{10, 7, -1});
        plans.push_back('{10, 8, -1});
        wait_starts(17, 500, "wait_stall_batch");
        uart_ready = 1'b0;
        nst = start_log.size();
        ne = ena_log.size();
        repeat (300) tick();
        check("stall_no_start", start_log.size(), nst);
        check("stall_no_ena", ena_log.size(), ne);
        uart_ready = 1'b1;
        r = cyc;
        repeat (3) tick();
        if (ena_log.size() > ne && start_log.size() > nst) begin
            check("stall_release_ena", ena_log[ne], r + 1);
            check("stall_release_data", data_log[ne], 6);
            check("stall_release_start", start_log[nst], r + 2);
        end else begin
            check("stall_release_seen", 0, 1);
        end
        repeat (50) tick();
        check("no_start_burst", start_log.size(), nst + 1);

        // random soak
        repeat (3000) begin
            tick();
            uart_ready = ($urandom_range(0, 9) < 7);
        end
        uart_ready = 1'b1;

        // test 6a: run_en drop during WAIT_DONE
        plans.push_back('{10, 7, -1});
        nst = start_log.size();
        wait_starts(nst + 1, 600, "wait_last_start");
        repeat (3) tick();
        run_en = 1'b0;
        nst = start_log.size();
        repeat (300) tick();
        check("stop_no_start", start_log.size(), nst);
        check("stop_busy", busy, 0);

        // test 6b: reset while stalled in SEND
        plans.delete();
        for (int i = 0; i < 4; i++) plans.push_back('{10, 1000, -1});
        uart_ready = 1'b0;
        nst = start_log.size();
        run_en = 1'b1;
        wait_starts(nst + 4, 600, "wait_send_batch");
        s4 = start_log[start_log.size() - 1];
        ne = ena_log.size();
        for (int i = 0; i < 100 && cyc < s4 + 20; i++) tick();
        rst = 1'b1;
        tick();
        tick();
        check("rst_send_ena", uart_ena, 0);
        check("rst_send_busy", busy, 0);
        check("rst_send_data", uart_data, 0);
        check("rst_send_tcnt", timeout_cnt, 0);
        rst = 1'b0;
        run_en = 1'b0;
        uart_ready = 1'b1;
        repeat (10) tick();
        check("rst_send_no_ena", ena_log.size(), ne);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/acq_scheduler.md
# acq_scheduler

Measurement sequencer for the acoustic camera. It periodically triggers the microphone cross-correlation subsystem and waits for completion with a timeout. It samples the resulting direction angle, averages 2^AVG_LOG2 valid measurements, and hands the result to the UART transmitter with a ready/valid handshake. It sits in the 60 MHz domain between the external enable pad, `mic_subsys` / `bi_microphone`, and `uart_top`, replacing the direct pad-to-start and done-to-UART wiring.

## Interface
Parameters:
- `PERIOD_CYC`, 6_000_000: measurement period in clk cycles (100 ms at 60 MHz); min 4.
- `TIMEOUT_CYC`, 3_000_000: max cycles from `subsys_start` to `subsys_done`; must be < `PERIOD_CYC`.
- `ANGLE_LAT`, 2: cycles from `subsys_done` to a stable `angel_in`; range 1..15.
- `AVG_LOG2`, 2: log2 of the number of samples averaged per report; range 0..4.

Ports (one clock; reset is synchronous and active-high):
- `clk_60MHz` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `run_en` in 1: level enable (from `PAD_XC_EN`).
- `subsys_start` out 1: one-cycle start pulse to `mic_subsys`.
- `subsys_done` in 1: one-cycle completion pulse from `mic_subsys`.
- `angel_in` in 16 signed: angle from `bi_microphone`.
- `uart_data` out 16 signed: averaged angle to UART.
- `uart_ena` out 1: one-cycle transmit request.
- `uart_ready` in 1: UART idle/ready.
- `busy` out 1: FSM not in IDLE.
- `err_timeout` out 1: one-cycle pulse on timeout.
- `timeout_cnt` out 8: saturating timeout counter.

## Operation
- States: IDLE, START, WAIT_DONE, SETTLE, SEND, GAP. All outputs are registered.
- **IDLE.** Accumulator and sample count are cleared. If `run_en`=1, go to START.
- **START.** `subsys_start`=1 for exactly this cycle. Load the period counter with PERIOD_CYC-1 and the timeout counter with TIMEOUT_CYC-1. Go to WAIT_DONE.
- **Period counter.** Decrements every non-IDLE cycle and saturates at 0.
- **WAIT_DONE.** The timeout counter decrements each cycle.
  - `subsys_done`=1: go to SETTLE and load the lat counter with ANGLE_LAT-1. Done has priority over timeout in the same cycle.
  - Timeout counter at 0 with no done: pulse `err_timeout`, increment `timeout_cnt` (saturates at 255), drop this sample (accumulator and count kept), go to GAP.
- **SETTLE.** Count down ANGLE_LAT cycles, then sample `angel_in` exactly ANGLE_LAT cycles after the done cycle.
  - acc += sign-extended `angel_in`; acc width is 16+AVG_LOG2; count++.
  - If count reaches 2^AVG_LOG2, go to SEND; otherwise go to GAP.
- **SEND.** `uart_data` <= acc >>> AVG_LOG2 (arithmetic shift, floor rounding).
  - If `uart_ready`=1, pulse `uart_ena` one cycle, clear acc/count, go to GAP.
  - Otherwise hold in SEND with no pulse. The period counter keeps running and no new START is issued.
- **GAP.** Wait until the period counter is 0.
  - `run_en`=1: go to START.
  - `run_en`=0: go to IDLE, discarding the partial average.
  - If the period has already expired (e.g. after a long SEND stall), exit next cycle. There is no catch-up burst; at most one START per GAP exit.
- `run_en` deassertion mid-cycle does not abort: the current measurement and any pending SEND complete, and the block stops at GAP.
- `subsys_done` outside WAIT_DONE is ignored. `angel_in` is sampled only in SETTLE.
- `uart_data` holds its last value between reports. `timeout_cnt` clears only on reset.

## Timing
- **Reset.** All outputs are 0 (`uart_data`=0, `timeout_cnt`=0) and the state is IDLE. Reset mid-operation, including in SEND or WAIT_DONE, aborts immediately with no pulse on the following cycle.
- **Start latency.** `run_en` sampled 1 at edge k puts the FSM in START; `subsys_start`=1 in cycle k+1 relative to that edge, and `busy`=1 in the same cycle.
- **Start spacing.** Consecutive `subsys_start` pulses are exactly PERIOD_CYC cycles apart while measurements finish and the UART is ready.
- **Timeout.** `err_timeout` pulses TIMEOUT_CYC cycles after the `subsys_start` cycle.
- **Report latency.** `uart_ena` asserts ANGLE_LAT+1 cycles after the final `subsys_done` when `uart_ready`=1. `uart_data` is valid in the same cycle and held afterwards.

## Test plan
Bench parameters: PERIOD_CYC=100, TIMEOUT_CYC=40, ANGLE_LAT=2, AVG_LOG2=2.
1. Reset, then `run_en`=1 -> all outputs 0 during reset; `subsys_start` single-cycle pulses exactly 100 cycles apart; `busy`=1.
2. `subsys_done` 10 cycles after each start, angles 10, 20, 30, 41 -> exactly one `uart_ena`, `uart_data`=25, 3 cycles after the 4th done.
3. Angles -1, -2, -2, -2 -> `uart_data`=-2 (floor of -7/4); a done pulse injected in GAP is ignored.
4. No done for one measurement -> `err_timeout` 40 cycles after start, `timeout_cnt`=1; next start still at +100; the report is issued after 4 valid samples.
5. `uart_ready`=0 for 300 cycles at SEND -> no `uart_ena`, no `subsys_start`; when ready rises, one `uart_ena` follows, then a start the next possible cycle; no burst of starts.
6. `run_en`=0 during WAIT_DONE -> the measurement completes, no further start, `busy`=0. Separately, `rst` in SEND -> no `uart_ena` and all outputs 0.
